// File: rtl/pc_gen_unit.sv
// Fetch-PC generator: PC register, branch/JALR target, misaligned-target trap, optional return-address stack.
// Optional feature: define PCGEN_RAS_EN to build the return-address stack.
module pc_gen_unit #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_stall,
    input  logic [1:0]      i_pc_src,
    input  logic [XLEN-1:0] i_pc_ex,
    input  logic [XLEN-1:0] i_imm,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_trap_vec,
    input  logic            i_ras_push,
    input  logic            i_ras_pop,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc_plus4,
    output logic [XLEN-1:0] o_pc_target,
    output logic            o_misalign,
    output logic [XLEN-1:0] o_bad_addr,
    output logic [XLEN-1:0] o_ras_top,
    output logic            o_ras_valid
);

    typedef enum logic [1:0] {
        SRC_SEQ  = 2'b00,
        SRC_BR   = 2'b01,
        SRC_JALR = 2'b10,
        SRC_TRAP = 2'b11
    } pc_src_e;

    logic [XLEN-1:0] r_pc;
    logic            r_misalign;
    logic [XLEN-1:0] r_bad_addr;
    logic [XLEN-1:0] w_br_target;
    logic [XLEN-1:0] w_jalr_sum;
    logic [XLEN-1:0] w_pc_next;
    logic            w_redirect;
    logic            w_misalign;
    pc_src_e         w_src;

    assign w_src       = pc_src_e'(i_pc_src);
    assign w_br_target = i_pc_ex + i_imm;
    assign w_jalr_sum  = i_rs1 + i_imm;
    assign o_pc_target = (w_src == SRC_JALR) ? {w_jalr_sum[XLEN-1:1], 1'b0} : w_br_target;
    assign o_pc_plus4  = r_pc + XLEN'(4);
    assign w_redirect  = (w_src == SRC_BR) || (w_src == SRC_JALR);
    assign w_misalign  = w_redirect && (o_pc_target[1:0] != 2'b00);

    // Next-PC priority: misaligned trap, redirect, trap, stall hold, sequential
    always_comb begin
        w_pc_next = r_pc;
        if (w_misalign) begin
            w_pc_next = i_trap_vec;
        end else if (w_redirect) begin
            w_pc_next = o_pc_target;
        end else if (w_src == SRC_TRAP) begin
            w_pc_next = i_trap_vec;
        end else if (!i_stall) begin
            w_pc_next = o_pc_plus4;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc       <= RESET_VECTOR;
            r_misalign <= 1'b0;
            r_bad_addr <= '0;
        end else begin
            r_pc       <= w_pc_next;
            r_misalign <= w_misalign;
            if (w_misalign) begin
                r_bad_addr <= o_pc_target;
            end
        end
    end

    assign o_pc       = r_pc;
    assign o_misalign = r_misalign;
    assign o_bad_addr = r_bad_addr;

`ifdef PCGEN_RAS_EN
    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0]  r_ras [RAS_DEPTH];
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [PTR_W-1:0] w_ptr_inc;
    logic [XLEN-1:0]  w_ret_addr;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;
    logic             w_do_repl;

    assign w_ptr_inc  = r_ptr + PTR_W'(1);
    assign w_ret_addr = i_pc_ex + XLEN'(4);
    assign w_empty    = (r_cnt == '0);
    // Push+pop on an empty stack degenerates to a plain push
    assign w_do_push  = i_ras_push && (!i_ras_pop || w_empty);
    assign w_do_pop   = i_ras_pop && !i_ras_push && !w_empty;
    assign w_do_repl  = i_ras_push && i_ras_pop && !w_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
            r_cnt <= '0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                r_ras[i] <= '0;
            end
        end else if (w_do_push) begin
            r_ras[w_ptr_inc] <= w_ret_addr;
            r_ptr            <= w_ptr_inc;
            if (r_cnt != CNT_W'(RAS_DEPTH)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else if (w_do_pop) begin
            r_ptr <= r_ptr - PTR_W'(1);
            r_cnt <= r_cnt - CNT_W'(1);
        end else if (w_do_repl) begin
            r_ras[r_ptr] <= w_ret_addr;
        end
    end

    assign o_ras_valid = !w_empty;
    assign o_ras_top   = w_empty ? '0 : r_ras[r_ptr];
`else
    logic w_unused_ras;

    assign w_unused_ras = i_ras_push ^ i_ras_pop;
    assign o_ras_top    = '0;
    assign o_ras_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed bench for pc_gen_unit: vector table for next-PC selection plus reset and RAS sequences.
module tb_pc_gen_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [1:0]  pc_src;
    logic [31:0] pc_ex, imm, rs1, trap_vec;
    logic        ras_push, ras_pop;
    logic [31:0] pc, pc_plus4, pc_target, bad_addr, ras_top;
    logic        misalign, ras_valid;

    int errors = 0;
    int checks = 0;

    pc_gen_unit #(.XLEN(32), .RESET_VECTOR(32'h0000_0000), .RAS_DEPTH(4)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_stall    (stall),
        .i_pc_src   (pc_src),
        .i_pc_ex    (pc_ex),
        .i_imm      (imm),
        .i_rs1      (rs1),
        .i_trap_vec (trap_vec),
        .i_ras_push (ras_push),
        .i_ras_pop  (ras_pop),
        .o_pc       (pc),
        .o_pc_plus4 (pc_plus4),
        .o_pc_target(pc_target),
        .o_misalign (misalign),
        .o_bad_addr (bad_addr),
        .o_ras_top  (ras_top),
        .o_ras_valid(ras_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic [1:0]  src;
        logic [31:0] pc_ex;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic        mis;
        logic [31:0] bad;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ras_op(input logic push, input logic pop, input logic [31:0] ex);
        ras_push = push;
        ras_pop  = pop;
        pc_ex    = ex;
        tick();
        ras_push = 1'b0;
        ras_pop  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] model_pc;

        vecs[0]  = '{1'b0, 2'b00, 32'h0,         32'h0,         32'h0,         32'h0,         32'h0000_0004, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 2'b00, 32'h0,         32'h0,         32'h0,         32'h0,         32'h0000_0008, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 2'b00, 32'h0,         32'h0,         32'h0,         32'h0,         32'h0000_000C, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 2'b01, 32'h0000_0100, 32'hFFFF_FFFC, 32'h0,         32'h0000_00FC, 32'h0000_00FC, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 2'b01, 32'h0000_0100, 32'hFFFF_FFFC, 32'h0,         32'h0000_00FC, 32'h0000_00FC, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 2'b00, 32'h0000_0100, 32'hFFFF_FFFC, 32'h0,         32'h0000_00FC, 32'h0000_00FC, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 2'b10, 32'h0,         32'h0,         32'h0000_1001, 32'h0000_1000, 32'h0000_1000, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 2'b10, 32'h0,         32'h0,         32'h0000_1002, 32'h0000_1002, 32'h0000_0800, 1'b1, 32'h0000_1002};
        vecs[8]  = '{1'b0, 2'b00, 32'h0,         32'h0,         32'h0,         32'h0,         32'h0000_0804, 1'b0, 32'h0000_1002};
        vecs[9]  = '{1'b0, 2'b11, 32'h0000_0010, 32'h0000_0002, 32'h0,         32'h0000_0012, 32'h0000_0800, 1'b0, 32'h0000_1002};
        vecs[10] = '{1'b0, 2'b01, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0,         32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_1002};
        vecs[11] = '{1'b0, 2'b01, 32'h0000_0010, 32'h0000_0002, 32'h0,         32'h0000_0012, 32'h0000_0800, 1'b1, 32'h0000_0012};
        vecs[12] = '{1'b0, 2'b01, 32'hFFFF_FFF0, 32'h0000_000C, 32'h0,         32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 32'h0000_0012};
        vecs[13] = '{1'b0, 2'b00, 32'h0,         32'h0,         32'h0,         32'h0,         32'h0000_0000, 1'b0, 32'h0000_0012};
        vecs[14] = '{1'b0, 2'b10, 32'h0,         32'h0000_0007, 32'h0000_2000, 32'h0000_2006, 32'h0000_0800, 1'b1, 32'h0000_2006};
        vecs[15] = '{1'b0, 2'b10, 32'h0,         32'h0000_0005, 32'h0000_2000, 32'h0000_2004, 32'h0000_2004, 1'b0, 32'h0000_2006};

        rst = 1'b1; stall = 1'b0; pc_src = 2'b00;
        pc_ex = '0; imm = '0; rs1 = '0; trap_vec = 32'h0000_0800;
        ras_push = 1'b0; ras_pop = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        chk("reset_pc", pc, 32'h0);
        chk("reset_misalign", 32'(misalign), 32'h0);
        chk("reset_bad_addr", bad_addr, 32'h0);
        chk("reset_ras_valid", 32'(ras_valid), 32'h0);
        chk("reset_ras_top", ras_top, 32'h0);

        model_pc = 32'h0;
        for (int i = 0; i < NVEC; i++) begin
            stall  = vecs[i].stall;
            pc_src = vecs[i].src;
            pc_ex  = vecs[i].pc_ex;
            imm    = vecs[i].imm;
            rs1    = vecs[i].rs1;
            #1;
            chk($sformatf("v%0d_target", i), pc_target, vecs[i].tgt);
            chk($sformatf("v%0d_plus4", i), pc_plus4, model_pc + 32'd4);
            tick();
            chk($sformatf("v%0d_pc", i), pc, vecs[i].pc);
            chk($sformatf("v%0d_misalign", i), 32'(misalign), 32'(vecs[i].mis));
            chk($sformatf("v%0d_bad_addr", i), bad_addr, vecs[i].bad);
            model_pc = vecs[i].pc;
        end
        stall = 1'b0; pc_src = 2'b00; imm = '0; rs1 = '0;

        // Reset asserted together with a misaligned redirect and a push
        pc_src = 2'b01; pc_ex = 32'h0000_0010; imm = 32'h0000_0002;
        tick();
        chk("pre_rst_misalign", 32'(misalign), 32'h1);
        ras_push = 1'b1; pc_ex = 32'h0000_0100;
        tick();
        ras_push = 1'b0;
        rst = 1'b1; ras_push = 1'b1; pc_src = 2'b01; imm = 32'h0000_0002;
        tick();
        rst = 1'b0; ras_push = 1'b0; pc_src = 2'b00; imm = '0;
        chk("rst_pc", pc, 32'h0);
        chk("rst_misalign", 32'(misalign), 32'h0);
        chk("rst_bad_addr", bad_addr, 32'h0);
        chk("rst_ras_valid", 32'(ras_valid), 32'h0);
        stall = 1'b1;

`ifdef PCGEN_RAS_EN
        // Five pushes into a four-deep stack, then drain it
        for (int k = 1; k <= 5; k++) begin
            ras_op(1'b1, 1'b0, 32'(k * 16));
            chk($sformatf("push%0d_top", k), ras_top, 32'(k * 16 + 4));
        end
        ras_op(1'b0, 1'b1, 32'h0);
        chk("pop1_top", ras_top, 32'h44);
        ras_op(1'b0, 1'b1, 32'h0);
        chk("pop2_top", ras_top, 32'h34);
        ras_op(1'b0, 1'b1, 32'h0);
        chk("pop3_top", ras_top, 32'h24);
        chk("pop3_valid", 32'(ras_valid), 32'h1);
        ras_op(1'b0, 1'b1, 32'h0);
        chk("pop4_valid", 32'(ras_valid), 32'h0);
        chk("pop4_top", ras_top, 32'h0);
        ras_op(1'b0, 1'b1, 32'h0);
        chk("pop_empty_valid", 32'(ras_valid), 32'h0);
        ras_op(1'b1, 1'b1, 32'h90);
        chk("pushpop_empty_top", ras_top, 32'h94);
        chk("pushpop_empty_valid", 32'(ras_valid), 32'h1);
        ras_op(1'b1, 1'b0, 32'h70);
        chk("push70_top", ras_top, 32'h74);
        ras_op(1'b1, 1'b1, 32'h60);
        chk("pushpop_top", ras_top, 32'h64);
        ras_op(1'b0, 1'b1, 32'h0);
        chk("pushpop_then_pop_top", ras_top, 32'h94);
        ras_op(1'b0, 1'b1, 32'h0);
        chk("pushpop_then_empty", 32'(ras_valid), 32'h0);
`else
        for (int k = 1; k <= 3; k++) begin
            ras_op(1'b1, 1'b0, 32'(k * 16));
            chk($sformatf("noras_push%0d_valid", k), 32'(ras_valid), 32'h0);
            chk($sformatf("noras_push%0d_top", k), ras_top, 32'h0);
        end
        ras_op(1'b1, 1'b1, 32'h60);
        chk("noras_pushpop_valid", 32'(ras_valid), 32'h0);
        chk("noras_pushpop_top", ras_top, 32'h0);
`endif
        chk("stall_hold_pc", pc, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_gen_unit.md
# pc_gen_unit

Parametrised fetch-PC generator for the RV32 core: holds the program-counter register and computes PC+4, branch/JAL target (pc_ex + imm) and JALR target ((rs1 + imm) & ~1). It selects the next PC under stall and redirect control, traps misaligned targets to a vector, and optionally provides a return-address stack for call/return prediction. It sits between the execute-stage branch resolution and the instruction-memory address port.

## Interface
Parameters:
- XLEN, 32, datapath/address width
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
- RAS_DEPTH, 4, return-address-stack entries (power of two, ≥2)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- stall  in  1  hold PC (fetch stall)
- pc_src  in  2  00 sequential, 01 branch/JAL, 10 JALR, 11 trap
- pc_ex  in  XLEN  PC of instruction resolving in execute
- imm  in  XLEN  sign-extended immediate
- rs1  in  XLEN  JALR base register value
- trap_vec  in  XLEN  trap handler address
- ras_push  in  1  call retired in execute: push pc_ex+4
- ras_pop  in  1  return retired in execute: pop
- pc  out  XLEN  registered fetch PC
- pc_plus4  out  XLEN  pc + 4, combinational
- pc_target  out  XLEN  selected target (branch or JALR form), combinational
- misalign  out  1  registered one-cycle pulse: misaligned target trapped
- bad_addr  out  XLEN  last misaligned target, registered
- ras_top  out  XLEN  top-of-stack prediction
- ras_valid  out  1  stack non-empty

## Operation
- pc_target = pc_ex + imm for pc_src 01; (rs1 + imm) with bit 0 cleared for pc_src 10; pc_ex + imm otherwise. All sums modulo 2^XLEN, carry discarded.
- Misaligned target: pc_src 01/10 and pc_target[1:0] != 0.
- Next-PC priority at each edge: rst → RESET_VECTOR; else misaligned redirect → trap_vec, misalign=1, bad_addr←pc_target; else pc_src 01/10 → pc_target; else pc_src 11 → trap_vec; else stall → hold; else pc_plus4.
- Redirects (pc_src ≠ 00) override stall.
- pc_plus4 wraps: pc=FFFF_FFFC → 0000_0000.
- RAS: circular buffer with pointer and count (0..RAS_DEPTH).
  - push only: write pc_ex+4 at ptr+1, ptr++, count saturates at RAS_DEPTH (oldest entry overwritten on overflow).
  - pop only: ptr--, count-- if count>0; pop on empty ignored.
  - push+pop same cycle: overwrite top entry with pc_ex+4, ptr and count unchanged (if empty, behaves as push).
  - ras_top = entry[ptr] when count>0, else 0; ras_valid = (count>0).
  - RAS updates are independent of stall and redirect.

## Timing
- pc, misalign, bad_addr, RAS state update on rising clk; pc_plus4, pc_target, ras_top, ras_valid derive combinationally from registers/inputs.
- Redirect latency: pc_src sampled at edge N, pc shows target after edge N.
- misalign high exactly one cycle (the cycle pc = trap_vec), then 0 unless re-triggered.
- Reset values: pc=RESET_VECTOR, misalign=0, bad_addr=0, RAS count=0, ptr=0, ras_valid=0, ras_top=0.
- rst mid-redirect or mid-push: reset wins; no partial update.

## Configuration
- PCGEN_RAS_EN defined: RAS built as above.
- Not defined: RAS logic omitted; ras_push/ras_pop ignored, ras_top=0, ras_valid=0 constantly; ports remain for a stable interface.

## Test plan
- Reset then 3 free-running cycles, stall=0, pc_src=00 → pc 0000_0000, 0000_0004, 0000_0008, 0000_000C.
- pc_ex=0000_0100, imm=FFFF_FFFC, pc_src=01 → pc=0000_00FC next cycle; same with stall=1 → still 0000_00FC.
- pc_src=10, rs1=0000_1001, imm=0000_0000 → pc=0000_1000; rs1=0000_1002 → pc=trap_vec, misalign=1 one cycle, bad_addr=0000_1002.
- pc=FFFF_FFFC, pc_src=00 → pc=0000_0000; pc_ex=7FFF_FFFF, imm=1, pc_src=01 → pc=8000_0000.
- PCGEN_RAS_EN, RAS_DEPTH=4: push pc_ex=10,20,30,40,50 → ras_top=54, count=4; pop×4 → 44,34,24 then ras_valid=0; extra pop ignored; push+pop with pc_ex=60 on non-empty → top=64, count unchanged.
- Assert rst during pc_src=01 with ras_push=1 → pc=RESET_VECTOR, ras_valid=0, misalign=0.
